// File: rtl/nibble_match_pkg.sv
// Shared types and helpers for the nibble-match accumulator slice.
// Used by nibble_match_accum and nma_window.
package nibble_match_pkg;

  localparam int CNT_W = 3;

  typedef enum logic {
    PRIME,
    RUN
  } acc_state_t;

  typedef enum logic {
    SNAP_IDLE,
    SNAP_PRESENT
  } snap_state_t;

  // Natural 3-bit subtraction gives the wrapped distance (prev 7, cur 0 -> 1).
  function automatic logic [CNT_W-1:0] delta_mod8(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] prev);
    return cur - prev;
  endfunction

endpackage

// File: rtl/nma_window.sv
// Fixed-length window counter: sums per-cycle deltas over 2**WIN_W RUN cycles,
// publishes the completed count and drives a hysteretic rate alarm from it.
module nma_window
  import nibble_match_pkg::*;
#(
  parameter int WIN_W  = 8,
  parameter int THR_HI = 64,
  parameter int THR_LO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] delta,
  input  logic             run,
  input  logic             clr,
  output logic [WIN_W:0]   win_last,
  output logic             alarm
);

  localparam logic [WIN_W-1:0] WIN_TERM = '1;
  localparam logic [WIN_W:0]   THR_HI_W = (WIN_W+1)'(THR_HI);
  localparam logic [WIN_W:0]   THR_LO_W = (WIN_W+1)'(THR_LO);

  logic [WIN_W-1:0] win_cnt_reg,  win_cnt_next;
  logic [WIN_W:0]   win_acc_reg,  win_acc_next;
  logic [WIN_W:0]   win_last_reg, win_last_next;
  logic             alarm_reg,    alarm_next;
  logic [WIN_W:0]   win_sum;

  assign win_sum = win_acc_reg + (WIN_W+1)'(delta);

  always_comb begin
    win_cnt_next  = win_cnt_reg;
    win_acc_next  = win_acc_reg;
    win_last_next = win_last_reg;
    alarm_next    = alarm_reg;
    // clr wins over a coincident terminal cycle, so nothing is published.
    if (clr) begin
      win_cnt_next  = '0;
      win_acc_next  = '0;
      win_last_next = '0;
      alarm_next    = 1'b0;
    end else if (run) begin
      if (win_cnt_reg == WIN_TERM) begin
        win_cnt_next  = '0;
        win_acc_next  = '0;
        win_last_next = win_sum;
        if (win_sum >= THR_HI_W) begin
          alarm_next = 1'b1;
        end else if (win_sum < THR_LO_W) begin
          alarm_next = 1'b0;
        end
      end else begin
        win_cnt_next = win_cnt_reg + 1'b1;
        win_acc_next = win_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_reg  <= '0;
      win_acc_reg  <= '0;
      win_last_reg <= '0;
      alarm_reg    <= 1'b0;
    end else begin
      win_cnt_reg  <= win_cnt_next;
      win_acc_reg  <= win_acc_next;
      win_last_reg <= win_last_next;
      alarm_reg    <= alarm_next;
    end
  end

  assign win_last = win_last_reg;
  assign alarm    = alarm_reg;

endmodule

// File: rtl/nibble_match_accum.sv
// Accumulates the wrapping 3-bit match counter into a saturating total and
// hands snapshots out over valid/ack. Macro NIBBLE_MATCH_ACCUM_ERR_EN enables the sticky err flag.
module nibble_match_accum
  import nibble_match_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int WIN_W  = 8,
  parameter int THR_HI = 64,
  parameter int THR_LO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             snap_valid,
  output logic [ACC_W-1:0] snap_total,
  output logic [WIN_W:0]   snap_win,
  output logic             alarm,
  output logic             err
);

  acc_state_t       acc_state_reg, acc_state_next;
  logic [CNT_W-1:0] prev_cnt_reg,  prev_cnt_next;
  logic [ACC_W-1:0] total_reg,     total_next;
  logic [CNT_W-1:0] delta;
  logic [ACC_W:0]   total_sum;
  logic             run;
  logic [WIN_W:0]   win_last;

  assign delta     = delta_mod8(cnt_in, prev_cnt_reg);
  assign total_sum = {1'b0, total_reg} + (ACC_W+1)'(delta);
  assign run       = (acc_state_reg == RUN);

  always_comb begin
    acc_state_next = acc_state_reg;
    prev_cnt_next  = prev_cnt_reg;
    total_next     = total_reg;
    if (clr) begin
      acc_state_next = PRIME;
      total_next     = '0;
    end else begin
      case (acc_state_reg)
        // First sample after reset/clr only establishes the reference count.
        PRIME: begin
          prev_cnt_next  = cnt_in;
          acc_state_next = RUN;
        end
        RUN: begin
          prev_cnt_next = cnt_in;
          total_next    = total_sum[ACC_W] ? '1 : total_sum[ACC_W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state_reg <= PRIME;
      prev_cnt_reg  <= '0;
      total_reg     <= '0;
    end else begin
      acc_state_reg <= acc_state_next;
      prev_cnt_reg  <= prev_cnt_next;
      total_reg     <= total_next;
    end
  end

  nma_window #(
    .WIN_W  (WIN_W),
    .THR_HI (THR_HI),
    .THR_LO (THR_LO)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .delta    (delta),
    .run      (run),
    .clr      (clr),
    .win_last (win_last),
    .alarm    (alarm)
  );

`ifdef NIBBLE_MATCH_ACCUM_ERR_EN
  logic err_reg, err_next;

  always_comb begin
    err_next = err_reg;
    if (clr) begin
      err_next = 1'b0;
    end else if (run && (delta > CNT_W'(1))) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // Snapshot handshake; deliberately independent of clr.
  snap_state_t      snap_state_reg, snap_state_next;
  logic             capture_en;
  logic [ACC_W-1:0] snap_total_reg;
  logic [WIN_W:0]   snap_win_reg;

  always_comb begin
    snap_state_next = snap_state_reg;
    capture_en      = 1'b0;
    snap_valid      = 1'b0;
    case (snap_state_reg)
      SNAP_IDLE: begin
        if (snap_req) begin
          snap_state_next = SNAP_PRESENT;
          capture_en      = 1'b1;
        end
      end
      SNAP_PRESENT: begin
        snap_valid = 1'b1;
        if (snap_ack) begin
          snap_state_next = SNAP_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_state_reg <= SNAP_IDLE;
    end else begin
      snap_state_reg <= snap_state_next;
    end
  end

  // Captures the register values as they stand before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_total_reg <= '0;
      snap_win_reg   <= '0;
    end else if (capture_en) begin
      snap_total_reg <= total_reg;
      snap_win_reg   <= win_last;
    end
  end

  assign snap_total = snap_total_reg;
  assign snap_win   = snap_win_reg;

endmodule

// File: tb/tb_nibble_match_accum.sv
// Directed bench for nibble_match_accum with a snapshot scoreboard fed by a
// small behavioural model (small ACC_W/WIN_W so saturation and windows are quick).
module tb_nibble_match_accum;

  localparam int ACC_W   = 4;
  localparam int WIN_W   = 4;
  localparam int THR_HI  = 8;
  localparam int THR_LO  = 4;
  localparam int WIN_LEN = 1 << WIN_W;
  localparam int TOT_MAX = (1 << ACC_W) - 1;
`ifdef NIBBLE_MATCH_ACCUM_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       cnt_in;
  logic             clr;
  logic             snap_req;
  logic             snap_ack;
  logic             snap_valid;
  logic [ACC_W-1:0] snap_total;
  logic [WIN_W:0]   snap_win;
  logic             alarm;
  logic             err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int total;
    int win;
  } snap_t;
  snap_t exp_q[$];

  // Behavioural model state
  bit m_prime;
  bit m_busy;
  int m_prev;
  int m_total;
  int m_win_cnt;
  int m_win_acc;
  int m_win_last;
  bit m_alarm;

  always #5 clk = ~clk;

  nibble_match_accum #(
    .ACC_W  (ACC_W),
    .WIN_W  (WIN_W),
    .THR_HI (THR_HI),
    .THR_LO (THR_LO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .snap_valid (snap_valid),
    .snap_total (snap_total),
    .snap_win   (snap_win),
    .alarm      (alarm),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies one clock edge to the model using the inputs the DUT sees at that edge.
  task automatic model_edge();
    int d;
    int wl;
    if (!m_busy) begin
      if (snap_req) begin
        exp_q.push_back('{m_total, m_win_last});
        m_busy = 1'b1;
      end
    end else if (snap_ack) begin
      m_busy = 1'b0;
    end
    if (clr) begin
      m_prime    = 1'b1;
      m_total    = 0;
      m_win_cnt  = 0;
      m_win_acc  = 0;
      m_win_last = 0;
      m_alarm    = 1'b0;
    end else if (m_prime) begin
      m_prev  = int'(cnt_in);
      m_prime = 1'b0;
    end else begin
      d       = (int'(cnt_in) - m_prev + 8) % 8;
      m_prev  = int'(cnt_in);
      m_total = (m_total + d > TOT_MAX) ? TOT_MAX : m_total + d;
      if (m_win_cnt == WIN_LEN - 1) begin
        wl         = m_win_acc + d;
        m_win_last = wl;
        m_win_acc  = 0;
        m_win_cnt  = 0;
        if (wl >= THR_HI) m_alarm = 1'b1;
        else if (wl < THR_LO) m_alarm = 1'b0;
      end else begin
        m_win_acc = m_win_acc + d;
        m_win_cnt = m_win_cnt + 1;
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic inc_tick();
    cnt_in = cnt_in + 3'd1;
    tick();
  endtask

  // Request a snapshot, then compare what is presented against the scoreboard.
  task automatic take_snap(input string tag);
    snap_t e;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk({tag, "_valid"}, snap_valid, 1);
    chk({tag, "_queue"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_sb_total"}, snap_total, e.total);
      chk({tag, "_sb_win"}, snap_win, e.win);
      $display("[TB] %s snapshot total=%0d win=%0d (expected %0d/%0d)",
               tag, snap_total, snap_win, e.total, e.win);
    end
  endtask

  task automatic ack_snap(input string tag);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk({tag, "_ack_valid"}, snap_valid, 0);
  endtask

  task automatic run_window(input string tag, input int hits, input int pre_alarm,
                            input int post_alarm);
    for (int i = 0; i < WIN_LEN - 1; i++) begin
      if (i < hits) inc_tick();
      else tick();
    end
    chk({tag, "_pre_alarm"}, alarm, pre_alarm);
    if (hits >= WIN_LEN) inc_tick();
    else tick();
    chk({tag, "_post_alarm"}, alarm, post_alarm);
  endtask

  task automatic clr_and_prime();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    snap_t e;
    rst_n    = 1'b0;
    cnt_in   = 3'd5;
    clr      = 1'b0;
    snap_req = 1'b0;
    snap_ack = 1'b0;
    m_prime = 1'b1; m_busy = 1'b0; m_prev = 0; m_total = 0;
    m_win_cnt = 0; m_win_acc = 0; m_win_last = 0; m_alarm = 1'b0;

    // 1: reset with cnt_in=5, then hold 5
    #12;
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_snap_total", snap_total, 0);
    chk("rst_snap_win", snap_win, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(10);
    chk("t1_alarm", alarm, 0);
    chk("t1_snap_valid", snap_valid, 0);
    take_snap("t1");
    chk("t1_total", snap_total, 0);
    ack_snap("t1");

    // 2: 6,7,0,1 after PRIME, wrap counted
    clr = 1'b1;
    tick();
    clr    = 1'b0;
    cnt_in = 3'd6;
    tick();
    cnt_in = 3'd7; tick();
    cnt_in = 3'd0; tick();
    cnt_in = 3'd1; tick();
    take_snap("t2");
    chk("t2_total", snap_total, 3);
    chk("t2_err", err, 0);
    ack_snap("t2");

    // 3: saturation at 15
    clr_and_prime();
    for (int i = 0; i < 20; i++) inc_tick();
    take_snap("t3a");
    chk("t3a_total", snap_total, TOT_MAX);
    ack_snap("t3a");
    for (int i = 0; i < 5; i++) inc_tick();
    take_snap("t3b");
    chk("t3b_total", snap_total, TOT_MAX);
    ack_snap("t3b");

    // ack while idle does nothing
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk("idle_ack_valid", snap_valid, 0);

    // 4: alarm hysteresis over three windows
    clr_and_prime();
    run_window("w1", 10, 0, 1);
    run_window("w2", 6, 1, 1);
    run_window("w3", 3, 1, 0);
    take_snap("t4");
    chk("t4_win", snap_win, 3);
    ack_snap("t4");

    // 5: held snapshot stays stable while the count grows
    clr_and_prime();
    for (int i = 0; i < 9; i++) inc_tick();
    take_snap("t5");
    chk("t5_total", snap_total, 9);
    snap_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inc_tick();
      chk("t5_hold_valid", snap_valid, 1);
      chk("t5_hold_total", snap_total, 9);
    end
    snap_req = 1'b0;
    ack_snap("t5");
    // back-to-back with snap_req held high
    snap_req = 1'b1;
    tick();
    chk("b2b_first_valid", snap_valid, 1);
    chk("b2b_first_q", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("b2b_first_total", snap_total, e.total);
    end
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk("b2b_gap_valid", snap_valid, 0);
    tick();
    chk("b2b_second_valid", snap_valid, 1);
    chk("b2b_second_q", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("b2b_second_total", snap_total, e.total);
    end
    snap_req = 1'b0;
    ack_snap("b2b");

    // 6: jump of 3 counts, err sticky, clr behaviour
    clr = 1'b1;
    tick();
    clr    = 1'b0;
    cnt_in = 3'd2;
    tick();
    cnt_in = 3'd5;
    tick();
    chk("t6_err_set", err, ERR_ON);
    tick(3);
    chk("t6_err_sticky", err, ERR_ON);
    take_snap("t6");
    chk("t6_total", snap_total, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr_valid", snap_valid, 1);
    chk("t6_clr_total", snap_total, 3);
    chk("t6_clr_err", err, 0);
    ack_snap("t6");
    // clr coincident with window terminal: nothing gets published
    for (int i = 0; i < WIN_LEN - 1; i++) begin
      if (i < 9) inc_tick();
      else tick();
    end
    cnt_in = cnt_in + 3'd1;
    clr    = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_term_alarm", alarm, 0);
    take_snap("t6b");
    chk("t6b_win", snap_win, 0);
    chk("t6b_total", snap_total, 0);
    ack_snap("t6b");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
